proc_control_unit_gen: RTL and testbench

- Parametrised next-generation control FSM for the simple bus-based processor.
- Extends the 4-instruction mv/mvi/add/sub controller to an 8-opcode ISA: adds and, ld, st, mvnz.
- Register count is parametrised, with one-hot register enables.
- Memory loads wait a configurable number of cycles.
- Sits between the IR and the datapath (register file, A/G registers, ALU, bus mux, memory address/data registers).

---
 rtl/proc_isa_pkg.sv | 32 +++
 rtl/reg_onehot_dec.sv | 25 ++
 rtl/proc_control_unit_gen.sv | 169 ++++++++++++++++
 tb/tb_proc_control_unit_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_isa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : proc_isa_pkg                                                     |
// | Brief    : Opcodes, ALU function codes and control-FSM state encoding for   |
// |            the 8-opcode bus-based processor.                                |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package proc_isa_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        TW = 3'd3,
        T3 = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_onehot_dec.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : reg_onehot_dec                                                   |
// | Brief    : Register-index to one-hot enable decoder with global enable.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module reg_onehot_dec #(
    parameter  int REG_BITS = 3,
    localparam int NREG     = 2**REG_BITS
) (
    input  logic [REG_BITS-1:0] idx,
    input  logic                en,
    output logic [NREG-1:0]     onehot
);

    // Each bit compares against its own index, so at most one bit is ever set.
    genvar k;
    generate
        for (k = 0; k < NREG; k++) begin : g_bit
            assign onehot[k] = en && (idx == REG_BITS'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/proc_control_unit_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : proc_control_unit_gen                                            |
// | Brief    : Control FSM for the bus-based processor: 8 opcodes, NREG         |
// |            registers with one-hot selects, ld with MEM_WAIT wait cycles.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module proc_control_unit_gen
    import proc_isa_pkg::*;
#(
    parameter  int REG_BITS = 3,
    parameter  int MEM_WAIT = 1,
    localparam int NREG     = 2**REG_BITS,
    localparam int IR_W     = 3 + 2*REG_BITS
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] IR,
    input  logic            G_nz,
    output logic            Done,
    output logic            IR_in,
    output logic            A_in,
    output logic            G_in,
    output logic            G_out,
    output logic            DIN_out,
    output logic [1:0]      alu_op,
    output logic            ADDR_in,
    output logic            DOUT_in,
    output logic            W_D,
    output logic [NREG-1:0] R_in,
    output logic [NREG-1:0] R_out
);

    // TW is entered with MEM_WAIT-1 loaded and left when the count hits zero,
    // giving exactly MEM_WAIT cycles in TW.
    localparam logic [3:0] c_WAIT_LOAD = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

    state_t                r_state;
    state_t                w_next;
    logic   [3:0]          r_wait_cnt;
    logic   [2:0]          w_op;
    logic   [REG_BITS-1:0] w_x;
    logic   [REG_BITS-1:0] w_y;
    logic                  w_rin_en;
    logic   [REG_BITS-1:0] w_rin_idx;
    logic                  w_rout_en;
    logic   [REG_BITS-1:0] w_rout_idx;

    assign w_op = IR[IR_W-1:IR_W-3];
    assign w_x  = IR[2*REG_BITS-1:REG_BITS];
    assign w_y  = IR[REG_BITS-1:0];

    // State register; asynchronous reset returns immediately to T0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= T0;
        else         r_state <= w_next;
    end

    // Memory wait counter: loaded on the T2->TW transition, counts down in TW.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                                 r_wait_cnt <= 4'd0;
        else if (r_state == T2 && w_next == TW)      r_wait_cnt <= c_WAIT_LOAD;
        else if (r_state == TW && r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
    end

    // Next-state and control decode from state, opcode and G_nz.
    always_comb begin
        w_next     = r_state;
        Done       = 1'b0;
        IR_in      = 1'b0;
        A_in       = 1'b0;
        G_in       = 1'b0;
        G_out      = 1'b0;
        DIN_out    = 1'b0;
        alu_op     = ALU_ADD;
        ADDR_in    = 1'b0;
        DOUT_in    = 1'b0;
        W_D        = 1'b0;
        w_rin_en   = 1'b0;
        w_rin_idx  = w_x;
        w_rout_en  = 1'b0;
        w_rout_idx = w_y;
        case (r_state)
            T0: begin
                IR_in = 1'b1;
                if (Run) w_next = T1;
            end
            T1: begin
                case (w_op)
                    OP_MV, OP_MVNZ: begin
                        if (w_op == OP_MV || G_nz) begin
                            w_rout_en = 1'b1;
                            w_rin_en  = 1'b1;
                        end
                        Done   = 1'b1;
                        w_next = T0;
                    end
                    OP_MVI: begin
                        DIN_out  = 1'b1;
                        w_rin_en = 1'b1;
                        Done     = 1'b1;
                        w_next   = T0;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_rout_idx = w_x;
                        w_rout_en  = 1'b1;
                        A_in       = 1'b1;
                        w_next     = T2;
                    end
                    default: begin
                        // ld / st: Y holds the address
                        w_rout_en = 1'b1;
                        ADDR_in   = 1'b1;
                        w_next    = T2;
                    end
                endcase
            end
            T2: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND: begin
                        w_rout_en = 1'b1;
                        G_in      = 1'b1;
                        alu_op    = (w_op == OP_ADD) ? ALU_ADD :
                                    (w_op == OP_SUB) ? ALU_SUB : ALU_AND;
                        w_next    = T3;
                    end
                    OP_ST: begin
                        w_rout_idx = w_x;
                        w_rout_en  = 1'b1;
                        DOUT_in    = 1'b1;
                        W_D        = 1'b1;
                        Done       = 1'b1;
                        w_next     = T0;
                    end
                    OP_LD: begin
                        w_next = (MEM_WAIT > 0) ? TW : T3;
                    end
                    default: w_next = T0;
                endcase
            end
            TW: begin
                if (r_wait_cnt == 4'd0) w_next = T3;
            end
            T3: begin
                if (w_op == OP_LD) DIN_out = 1'b1;
                else               G_out   = 1'b1;
                w_rin_en = 1'b1;
                Done     = 1'b1;
                w_next   = T0;
            end
            default: w_next = T0;
        endcase
    end

    reg_onehot_dec #(.REG_BITS(REG_BITS)) u_rin_dec (
        .idx    (w_rin_idx),
        .en     (w_rin_en),
        .onehot (R_in)
    );

    reg_onehot_dec #(.REG_BITS(REG_BITS)) u_rout_dec (
        .idx    (w_rout_idx),
        .en     (w_rout_en),
        .onehot (R_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_proc_control_unit_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_proc_control_unit_gen                                         |
// | Brief    : Directed-vector bench for proc_control_unit_gen; three instances |
// |            (REG_BITS=3/MEM_WAIT=2, REG_BITS=3/MEM_WAIT=0, REG_BITS=4).      |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_proc_control_unit_gen;

    // Packed control word: {Done, IR_in, A_in, G_in, G_out, DIN_out, alu_op, ADDR_in, DOUT_in, W_D}
    localparam logic [10:0] c_NONE  = 11'b000_0000_0000;
    localparam logic [10:0] c_DONE  = 11'b100_0000_0000;
    localparam logic [10:0] c_IRIN  = 11'b010_0000_0000;
    localparam logic [10:0] c_AIN   = 11'b001_0000_0000;
    localparam logic [10:0] c_GIN   = 11'b000_1000_0000;
    localparam logic [10:0] c_GOUT  = 11'b000_0100_0000;
    localparam logic [10:0] c_DIN   = 11'b000_0010_0000;
    localparam logic [10:0] c_SUB   = 11'b000_0000_1000;
    localparam logic [10:0] c_AND   = 11'b000_0001_0000;
    localparam logic [10:0] c_ADDR  = 11'b000_0000_0100;
    localparam logic [10:0] c_DOUT  = 11'b000_0000_0010;
    localparam logic [10:0] c_WD    = 11'b000_0000_0001;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        run = 1'b0;
    logic [10:0] ir = 11'd0;
    logic        G_nz = 1'b0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic run_a, run_b, run_c;
    assign run_a = run && (sel == 0);
    assign run_b = run && (sel == 1);
    assign run_c = run && (sel == 2);

    logic       done_a, irin_a, ain_a, gin_a, gout_a, din_a, addr_a, dout_a, wd_a;
    logic [1:0] alu_a;
    logic [7:0] rin_a, rout_a;
    logic       done_b, irin_b, ain_b, gin_b, gout_b, din_b, addr_b, dout_b, wd_b;
    logic [1:0] alu_b;
    logic [7:0] rin_b, rout_b;
    logic       done_c, irin_c, ain_c, gin_c, gout_c, din_c, addr_c, dout_c, wd_c;
    logic [1:0] alu_c;
    logic [15:0] rin_c, rout_c;

    proc_control_unit_gen #(.REG_BITS(3), .MEM_WAIT(2)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(run_a), .IR(ir[8:0]), .G_nz(G_nz),
        .Done(done_a), .IR_in(irin_a), .A_in(ain_a), .G_in(gin_a), .G_out(gout_a),
        .DIN_out(din_a), .alu_op(alu_a), .ADDR_in(addr_a), .DOUT_in(dout_a), .W_D(wd_a),
        .R_in(rin_a), .R_out(rout_a)
    );

    proc_control_unit_gen #(.REG_BITS(3), .MEM_WAIT(0)) dut_nowait (
        .Clock(Clock), .Resetn(Resetn), .Run(run_b), .IR(ir[8:0]), .G_nz(G_nz),
        .Done(done_b), .IR_in(irin_b), .A_in(ain_b), .G_in(gin_b), .G_out(gout_b),
        .DIN_out(din_b), .alu_op(alu_b), .ADDR_in(addr_b), .DOUT_in(dout_b), .W_D(wd_b),
        .R_in(rin_b), .R_out(rout_b)
    );

    proc_control_unit_gen #(.REG_BITS(4), .MEM_WAIT(1)) dut_r16 (
        .Clock(Clock), .Resetn(Resetn), .Run(run_c), .IR(ir), .G_nz(G_nz),
        .Done(done_c), .IR_in(irin_c), .A_in(ain_c), .G_in(gin_c), .G_out(gout_c),
        .DIN_out(din_c), .alu_op(alu_c), .ADDR_in(addr_c), .DOUT_in(dout_c), .W_D(wd_c),
        .R_in(rin_c), .R_out(rout_c)
    );

    always #5 Clock = ~Clock;

    // Observation of the instance currently under test
    logic [10:0] obs_ctl;
    logic [15:0] obs_rin, obs_rout;
    always_comb begin
        obs_ctl  = {done_a, irin_a, ain_a, gin_a, gout_a, din_a, alu_a, addr_a, dout_a, wd_a};
        obs_rin  = {8'd0, rin_a};
        obs_rout = {8'd0, rout_a};
        if (sel == 1) begin
            obs_ctl  = {done_b, irin_b, ain_b, gin_b, gout_b, din_b, alu_b, addr_b, dout_b, wd_b};
            obs_rin  = {8'd0, rin_b};
            obs_rout = {8'd0, rout_b};
        end else if (sel == 2) begin
            obs_ctl  = {done_c, irin_c, ain_c, gin_c, gout_c, din_c, alu_c, addr_c, dout_c, wd_c};
            obs_rin  = rin_c;
            obs_rout = rout_c;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        #13;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs_ctl !== c_IRIN || obs_rin !== 16'd0 || obs_rout !== 16'd0) begin
                $display("FAIL reset[%0d]: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0 R_out=0",
                         s, obs_ctl, obs_rin, obs_rout, c_IRIN);
                errors++;
            end
        end
        sel = 0;
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_mv();
        ir = 11'h015;  // mv R2,R5
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [10:0] ec;
            logic [15:0] ei, eo;
            ec = (i == 0) ? c_DONE : c_IRIN;
            ei = (i == 0) ? 16'h0004 : 16'h0000;
            eo = (i == 0) ? 16'h0020 : 16'h0000;
            checks++;
            if (obs_ctl !== ec || obs_rin !== ei || obs_rout !== eo) begin
                $display("FAIL mv cyc%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=%h R_out=%h",
                         i, obs_ctl, obs_rin, obs_rout, ec, ei, eo);
                errors++;
            end
            tick();
        end
    endtask

    // Runs an ALU instruction on the selected instance and checks T1..T3 plus the following T0
    task automatic test_alu(input string name, input int s, input logic [10:0] instr,
                            input logic [10:0] alu_bits, input logic [15:0] rx, input logic [15:0] ry);
        logic [10:0] ec [4];
        logic [15:0] ei [4];
        logic [15:0] eo [4];
        ec = '{c_AIN, c_GIN | alu_bits, c_GOUT | c_DONE, c_IRIN};
        ei = '{16'h0, 16'h0, rx, 16'h0};
        eo = '{rx, ry, 16'h0, 16'h0};
        sel = s;
        ir = instr;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_ctl !== ec[i] || obs_rin !== ei[i] || obs_rout !== eo[i]) begin
                $display("FAIL %s cyc%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=%h R_out=%h",
                         name, i, obs_ctl, obs_rin, obs_rout, ec[i], ei[i], eo[i]);
                errors++;
            end
            tick();
        end
        sel = 0;
    endtask

    // ld R4,[R6] with MEM_WAIT=2 (5 cycles) or MEM_WAIT=0 (3 cycles)
    task automatic test_ld(input int s);
        int n;
        logic [10:0] ec [6];
        logic [15:0] ei [6];
        logic [15:0] eo [6];
        n = (s == 0) ? 6 : 4;
        for (int i = 0; i < 6; i++) begin
            ec[i] = c_NONE;
            ei[i] = 16'h0;
            eo[i] = 16'h0;
        end
        ec[0] = c_ADDR;
        eo[0] = 16'h0040;
        ec[n-2] = c_DIN | c_DONE;
        ei[n-2] = 16'h0010;
        ec[n-1] = c_IRIN;
        sel = s;
        ir = 11'h126;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_ctl !== ec[i] || obs_rin !== ei[i] || obs_rout !== eo[i]) begin
                $display("FAIL ld_w%0d cyc%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=%h R_out=%h",
                         (s == 0) ? 2 : 0, i, obs_ctl, obs_rin, obs_rout, ec[i], ei[i], eo[i]);
                errors++;
            end
            tick();
        end
        sel = 0;
    endtask

    task automatic test_st();
        logic [10:0] ec [3];
        logic [15:0] ei [3];
        logic [15:0] eo [3];
        ec = '{c_ADDR, c_DOUT | c_WD | c_DONE, c_IRIN};
        ei = '{16'h0, 16'h0, 16'h0};
        eo = '{16'h0040, 16'h0002, 16'h0};
        ir = 11'h14E;  // st R1,[R6]
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_ctl !== ec[i] || obs_rin !== ei[i] || obs_rout !== eo[i]) begin
                $display("FAIL st cyc%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=%h R_out=%h",
                         i, obs_ctl, obs_rin, obs_rout, ec[i], ei[i], eo[i]);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_mvnz();
        for (int g = 0; g < 2; g++) begin
            logic [15:0] ei, eo;
            ei = (g == 1) ? 16'h0001 : 16'h0000;
            eo = (g == 1) ? 16'h0080 : 16'h0000;
            G_nz = (g == 1);
            ir = 11'h187;  // mvnz R0,R7
            run = 1'b1;
            tick();
            run = 1'b0;
            checks++;
            if (obs_ctl !== c_DONE || obs_rin !== ei || obs_rout !== eo) begin
                $display("FAIL mvnz g%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=%h R_out=%h",
                         g, obs_ctl, obs_rin, obs_rout, c_DONE, ei, eo);
                errors++;
            end
            tick();
        end
        G_nz = 1'b0;
    endtask

    task automatic test_back_to_back();
        ir = 11'h015;  // mv R2,R5
        run = 1'b1;
        tick();
        checks++;
        if (obs_ctl !== c_DONE || obs_rin !== 16'h0004 || obs_rout !== 16'h0020) begin
            $display("FAIL b2b_mv: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0004 R_out=0020",
                     obs_ctl, obs_rin, obs_rout, c_DONE);
            errors++;
        end
        tick();
        ir = 11'h058;  // mvi R3
        #1;
        checks++;
        if (obs_ctl !== c_IRIN || obs_rin !== 16'h0 || obs_rout !== 16'h0) begin
            $display("FAIL b2b_gap: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0 R_out=0",
                     obs_ctl, obs_rin, obs_rout, c_IRIN);
            errors++;
        end
        tick();
        run = 1'b0;
        checks++;
        if (obs_ctl !== (c_DIN | c_DONE) || obs_rin !== 16'h0008 || obs_rout !== 16'h0) begin
            $display("FAIL b2b_mvi: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0008 R_out=0",
                     obs_ctl, obs_rin, obs_rout, c_DIN | c_DONE);
            errors++;
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        ir = 11'h126;  // ld R4,[R6], MEM_WAIT=2
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();        // first TW cycle
        Resetn = 1'b0;
        #1;
        checks++;
        if (obs_ctl !== c_IRIN || obs_rin !== 16'h0 || obs_rout !== 16'h0) begin
            $display("FAIL rst_mid: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0 R_out=0",
                     obs_ctl, obs_rin, obs_rout, c_IRIN);
            errors++;
        end
        tick();
        Resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_ctl !== c_IRIN || obs_rin !== 16'h0 || obs_rout !== 16'h0) begin
                $display("FAIL rst_idle cyc%0d: ctl=%b R_in=%h R_out=%h required ctl=%b R_in=0 R_out=0",
                         i, obs_ctl, obs_rin, obs_rout, c_IRIN);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mv();
        test_alu("add", 0, 11'h08B, c_NONE, 16'h0002, 16'h0008);
        test_alu("sub", 0, 11'h0CB, c_SUB,  16'h0002, 16'h0008);
        test_alu("and", 0, 11'h1CB, c_AND,  16'h0002, 16'h0008);
        test_alu("add_xx", 0, 11'h09B, c_NONE, 16'h0008, 16'h0008);
        test_alu("add_r16", 2, 11'h29E, c_NONE, 16'h0200, 16'h4000);
        test_ld(0);
        test_ld(1);
        test_st();
        test_mvnz();
        test_back_to_back();
        test_reset_mid_op();
        test_ld(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
